// File: rtl/tog_counter_pkg.sv
// Shared mode encoding for tog_counter and its users.
// BIN/GRAY count, TOGGLE applies per-bit T flops, HOLD freezes the count.
package tog_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BIN    = 2'b00;
  localparam mode_t MODE_GRAY   = 2'b01;
  localparam mode_t MODE_TOGGLE = 2'b10;
  localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/tog_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is combinational on the last enabled cycle.
// clr restarts the division; pc holds while en is low.
module tog_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pc;

  assign tick = en && (pc == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (en) begin
      pc <= tick ? '0 : pc + PW'(1);
    end
  end

endmodule

// File: rtl/tog_counter.sv
// Prescaled binary/gray/toggle counter with parallel load and registered terminal-count pulse.
// q/qb decode combinationally from the state and the current mode.
module tog_counter
  import tog_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] stepped;

  tog_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    at_term = up_dn ? (&cnt) : (cnt == '0);
    stepped = up_dn ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      tc  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (tick) begin
        case (mode)
          MODE_BIN, MODE_GRAY: begin
            // tc flags any step taken at terminal, whether it wraps or saturates
            tc <= at_term;
            if (!(at_term && (SATURATE != 0))) begin
              cnt <= stepped;
            end
          end
          MODE_TOGGLE: cnt <= cnt ^ t_vec;
          default: ;
        endcase
      end
    end
  end

  assign q  = (mode == MODE_GRAY) ? (cnt ^ (cnt >> 1)) : cnt;
  assign qb = ~q;

endmodule

// File: tb/tb_tog_counter.sv
// Three tog_counter configurations share one stimulus stream; a reference model fills a
// scoreboard each cycle, plus directed checks on the documented sequences.
module tb_tog_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [1:0] mode;
  logic [3:0] load_val, t_vec;

  logic [3:0] q_o  [3];
  logic [3:0] qb_o [3];
  logic       tc_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  int ps  [3] = '{1, 1, 3};
  int sat [3] = '{0, 1, 0};
  int m_cnt [3];
  int m_pc  [3];
  bit m_tc  [3];

  typedef struct {
    int         k;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  tog_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .t_vec(t_vec), .q(q_o[0]), .qb(qb_o[0]), .tc(tc_o[0]));

  tog_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .t_vec(t_vec), .q(q_o[1]), .qb(qb_o[1]), .tc(tc_o[1]));

  tog_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) dut_pre (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .t_vec(t_vec), .q(q_o[2]), .qb(qb_o[2]), .tc(tc_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model with the inputs currently driven, then clock and drain the scoreboard.
  task automatic cyc();
    exp_t e;
    bit   tick;
    int   gq;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_pc[k] = 0; m_tc[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(load_val); m_pc[k] = 0; m_tc[k] = 0;
      end else begin
        tick = en && (m_pc[k] == ps[k] - 1);
        if (en) m_pc[k] = tick ? 0 : m_pc[k] + 1;
        m_tc[k] = 0;
        if (tick) begin
          if (mode == 2'b00 || mode == 2'b01) begin
            if (up_dn) begin
              if (m_cnt[k] == 15) begin m_tc[k] = 1; m_cnt[k] = sat[k] ? 15 : 0; end
              else m_cnt[k] = m_cnt[k] + 1;
            end else begin
              if (m_cnt[k] == 0) begin m_tc[k] = 1; m_cnt[k] = sat[k] ? 0 : 15; end
              else m_cnt[k] = m_cnt[k] - 1;
            end
          end else if (mode == 2'b10) begin
            m_cnt[k] = m_cnt[k] ^ int'(t_vec);
          end
        end
      end
      gq   = (mode == 2'b01) ? (m_cnt[k] ^ (m_cnt[k] >> 1)) : m_cnt[k];
      e.k  = k;
      e.q  = 4'(gq);
      e.qb = ~4'(gq);
      e.tc = m_tc[k];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("q%0d", e.k),  32'(q_o[e.k]),  32'(e.q));
      check($sformatf("qb%0d", e.k), 32'(qb_o[e.k]), 32'(e.qb));
      check($sformatf("tc%0d", e.k), 32'(tc_o[e.k]), 32'(e.tc));
    end
  endtask

  initial begin
    logic [3:0] prev_q;
    int gray_tab [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int en_pat [4] = '{1, 1, 0, 1};

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 2'b00;
    load = 1'b0; load_val = '0; t_vec = '0;
    cyc(); cyc();
    check("rst_q",  32'(q_o[0]),  32'h0);
    check("rst_qb", 32'(qb_o[0]), 32'hF);
    check("rst_tc", 32'(tc_o[0]), 32'h0);

    // Binary up count with wrap from reset
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check("bin_q",  32'(q_o[0]),  32'(i % 16));
      check("bin_tc", 32'(tc_o[0]), (i == 16) ? 32'h1 : 32'h0);
    end

    // Saturating down count from 1
    load = 1'b1; load_val = 4'd1; up_dn = 1'b0;
    cyc();
    check("sat_ld", 32'(q_o[1]), 32'h1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("sat_q",  32'(q_o[1]),  32'h0);
      check("sat_tc", 32'(tc_o[1]), (i > 0) ? 32'h1 : 32'h0);
    end

    // Prescale by 3 with gated enable, then load mid-prescale
    up_dn = 1'b1; load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = en_pat[i][0];
      cyc();
      check("pre_q", 32'(q_o[2]), (i == 3) ? 32'h1 : 32'h0);
    end
    en = 1'b1;
    cyc();
    load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("pre_ld_q", 32'(q_o[2]), (i == 2) ? 32'h6 : 32'h5);
    end

    // Gray up over a full cycle
    load = 1'b1; load_val = 4'd0; mode = 2'b01;
    cyc();
    load = 1'b0;
    prev_q = q_o[0];
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check("gray_q",   32'(q_o[0]), 32'(gray_tab[i]));
      check("gray_one", 32'($countones(q_o[0] ^ prev_q)), 32'h1);
      prev_q = q_o[0];
    end

    // Toggle mode
    load = 1'b1; load_val = 4'd0; mode = 2'b10; t_vec = 4'b0101;
    cyc();
    load = 1'b0;
    cyc();
    check("tog_q1", 32'(q_o[0]), 32'h5);
    check("tog_tc", 32'(tc_o[0]), 32'h0);
    cyc();
    check("tog_q2",  32'(q_o[0]),  32'h0);
    check("tog_qb2", 32'(qb_o[0]), 32'hF);

    // Reset wins over a coincident load
    load = 1'b1; load_val = 4'd0; mode = 2'b00;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    check("pre7_q", 32'(q_o[0]), 32'h7);
    reset = 1'b1; load = 1'b1; load_val = 4'hA;
    cyc();
    check("rl_q",  32'(q_o[0]),  32'h0);
    check("rl_tc", 32'(tc_o[0]), 32'h0);
    check("rl_qb", 32'(qb_o[0]), 32'hF);
    reset = 1'b0; load = 1'b0;

    // Random traffic including mid-count mode changes and HOLD
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 14) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      mode     = 2'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
      t_vec    = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tog_counter.md
TOG_COUNTER -- requirements
Module: tog_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/register width in bits (legal 2..32).
REQ-002 Parameter PRESCALE, default 1, number of enabled cycles per count step (legal 1..256).
REQ-003 Parameter SATURATE, default 0; 1 = stop at terminal value, 0 = wrap.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; gates prescaler and stepping.
REQ-007 up_dn  input  1  1 = count up, 0 = count down (binary/gray modes).
REQ-008 mode  input  2  00 BIN, 01 GRAY, 10 TOGGLE, 11 HOLD.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 load_val  input  WIDTH  value written to state on load.
REQ-011 t_vec  input  WIDTH  per-bit toggle enables (TOGGLE mode).
REQ-012 q  output  WIDTH  mode-decoded state.
REQ-013 qb  output  WIDTH  bitwise complement of q.
REQ-014 tc  output  1  registered terminal-count pulse.

Function
REQ-015 Internal state cnt (WIDTH bits) and prescaler count pc; priority per cycle: reset > load > step > hold.
REQ-016 tick = en && (pc == PRESCALE-1); when en, pc increments, returning to 0 on tick; when !en, pc holds; PRESCALE=1 gives tick = en.
REQ-017 load: cnt <= load_val, pc <= 0, tc <= 0, regardless of en, tick or mode.
REQ-018 Step occurs only on tick without load; HOLD mode: no step, cnt unchanged, pc still runs.
REQ-019 BIN/GRAY step: cnt <= cnt+1 (up_dn=1) or cnt-1 (up_dn=0), modulo 2^WIDTH.
REQ-020 Terminal: cnt == all-ones when up, cnt == 0 when down.
REQ-021 SATURATE=1: step at terminal leaves cnt unchanged; SATURATE=0: wraps (max->0 up, 0->max down).
REQ-022 tc is 1 for exactly the cycle after a BIN/GRAY step taken at terminal (wrap or saturate), else 0.
REQ-023 TOGGLE step: cnt <= cnt ^ t_vec (independent per-bit T flip-flops); up_dn, SATURATE ignored; tc stays 0.
REQ-024 q = cnt ^ (cnt >> 1) in GRAY, q = cnt otherwise; combinational from cnt and current mode, zero added latency.
REQ-025 qb = ~q at all times.
REQ-026 Mode change mid-count does not alter cnt or pc; only the q decode and next step rule change.
REQ-027 Consecutive GRAY up steps change exactly one bit of q, including at wrap.

Reset
REQ-028 On reset: cnt = 0, pc = 0, tc = 0; hence q = 0, qb = all-ones.
REQ-029 Reset asserted mid-prescale or coincident with load/tick overrides both; first step possible PRESCALE enabled cycles after reset release.

Structure
REQ-030 Package tog_counter_pkg holds the mode encoding constants (MODE_BIN, MODE_GRAY, MODE_TOGGLE, MODE_HOLD) and the 2-bit mode typedef.
REQ-031 Prescaler is a sub-module tog_prescaler (inputs clk, reset, en, clr; output tick; parameter PRESCALE); clr driven by load.
REQ-032 All state updates in a single clocked process per module; q/qb/tick decode combinational.

Verification
REQ-033 WIDTH=4, PRESCALE=1, BIN up, en=1 from reset: q 0,1,...,15,0; tc=1 only the cycle q returns to 0.
REQ-034 WIDTH=4, SATURATE=1, BIN down from load_val=1: q 1,0,0,0; tc=1 each cycle after step at 0.
REQ-035 WIDTH=4, PRESCALE=3, BIN up, en toggled 1,1,0,1: q steps only on 3rd enabled cycle; load mid-prescale restarts 3-cycle count.
REQ-036 WIDTH=4, GRAY up over 16 steps: q 0000,0001,0011,0010,...,1000,0000; single-bit change each step.
REQ-037 WIDTH=4, TOGGLE, cnt=0, t_vec=0101 for two steps: q 0101 then 0000; tc=0; qb = ~q throughout.
REQ-038 Load and reset asserted same cycle during count at q=7: next cycle q=0, tc=0, qb=1111.
